// File: rtl/data_mem_responder.sv
// Data-bus slave for the RV32I core: word/half/byte accesses with programmable
// wait states, ACKD_n handshake and a sticky error flag over a word-wide SRAM.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  output logic        ACKD_n,
  output logic        err,
  input  logic        err_clr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_l;
  logic          write_l;
  logic [1:0]    size_l;
  logic          bad_l;
  logic          drive;
  logic [31:0]   word_rd;
  logic [31:0]   rd_data;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          enter_ack;
  logic [AW+1:0] cur_addr;

  logic [31:0] mem [DEPTH_WORDS];

  // Base is aligned to the array span, so range is just an upper-bit match.
  function automatic logic is_bad(input logic [31:0] a, input logic [1:0] s);
    logic mis, oor;
    mis = (s == 2'b00 && a[1:0] != 2'b00) || (s == 2'b01 && a[0]);
    oor = a[31:AW+2] != BASE_ADDR[31:AW+2];
    return mis || oor || (s == 2'b11);
  endfunction

  assign enter_ack = (state == IDLE && MREQ && WAIT_CYCLES == 0) ||
                     (state == WAIT && MREQ && cnt == 4'd1);
  assign cur_addr  = (state == IDLE) ? DAD[AW+1:0] : addr_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ACKD_n  <= 1'b1;
      drive   <= 1'b0;
      err     <= 1'b0;
      cnt     <= 4'd0;
      addr_l  <= '0;
      write_l <= 1'b0;
      size_l  <= 2'b00;
      bad_l   <= 1'b0;
    end else begin
      ACKD_n <= 1'b1;
      drive  <= 1'b0;
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (MREQ) begin
            addr_l  <= DAD[AW+1:0];
            write_l <= WRITE;
            size_l  <= SIZE;
            bad_l   <= is_bad(DAD, SIZE);
            cnt     <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state  <= ACK;
              ACKD_n <= 1'b0;
              drive  <= !WRITE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!MREQ) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state  <= ACK;
              ACKD_n <= 1'b0;
              drive  <= !write_l;
            end
          end
        end
        default: begin
          state <= IDLE;
          if (bad_l) err <= 1'b1;
        end
      endcase
    end
  end

  // Lane steering of right-justified write data onto the addressed bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign be[gi] = (size_l == 2'b00) ||
                    (size_l == 2'b01 && addr_l[1] == 1'(gi / 2)) ||
                    (size_l == 2'b10 && addr_l[1:0] == 2'(gi));
    assign wdata[8*gi +: 8] = (size_l == 2'b00) ? DDT[8*gi +: 8] :
                              (size_l == 2'b01) ? DDT[8*(gi % 2) +: 8] :
                                                  DDT[7:0];
  end

  always_ff @(posedge clk) begin
    if (enter_ack) word_rd <= mem[cur_addr[AW+1:2]];
    if (state == ACK && write_l && !bad_l) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_l[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (!bad_l) begin
      case (size_l)
        2'b00:   rd_data = word_rd;
        2'b01:   rd_data = {16'h0, addr_l[1] ? word_rd[31:16] : word_rd[15:0]};
        2'b10: begin
          case (addr_l[1:0])
            2'd0:    rd_data = {24'h0, word_rd[7:0]};
            2'd1:    rd_data = {24'h0, word_rd[15:8]};
            2'd2:    rd_data = {24'h0, word_rd[23:16]};
            default: rd_data = {24'h0, word_rd[31:24]};
          endcase
        end
        default: rd_data = 32'h0;
      endcase
    end
  end

  assign DDT = drive ? rd_data : 32'bz;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Behavioural-synthesizable data-memory responder for the RV32I core's data bus. It is the slave end of the `DAD`/`DDT`/`MREQ`/`WRITE`/`SIZE`/`ACKD_n` protocol. It accepts word, halfword and byte requests, inserts a programmable number of wait states, and acknowledges with `ACKD_n`. It holds a word-organised SRAM array, and the CPU and testbenches use it as the system data memory.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 1: wait states between request capture and acknowledge, in the range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-high: one clock, reset is asynchronous and active-high.
- `DAD`  in  32  byte address from the initiator.
- `DDT`  inout  32  data bus. The responder drives it only during a read ACK cycle and otherwise leaves it `32'bz`.
- `MREQ`  in  1  request: 1 = access.
- `WRITE`  in  1  1 = write, 0 = read; valid while `MREQ`=1.
- `SIZE`  in  2  access size: 2'b00 = word, 2'b01 = halfword, 2'b10 = byte, 2'b11 = reserved.
- `ACKD_n`  out  1  acknowledge: 0 = access completes this cycle, 1 = not ready.
- `err`  out  1  sticky error flag, set by a misaligned, out-of-range or reserved-size access.
- `err_clr`  in  1  synchronous clear of `err`; a set event in the same cycle wins.

## Operation
- Byte order is little-endian. Word index = `(addr - BASE_ADDR) >> 2`. Lane = `addr[1:0]`.
- State machine `IDLE` -> `WAIT` -> `ACK` -> `IDLE`.
  - `IDLE`: when `MREQ`=1, latch `DAD`, `WRITE` and `SIZE`, and load the wait counter with `WAIT_CYCLES`. Go to `ACK` if `WAIT_CYCLES`=0, otherwise to `WAIT`.
  - `WAIT`: decrement the counter each cycle and go to `ACK` when the counter reaches 1.
    - If `MREQ` falls during `WAIT`, this is an abort: return to `IDLE` with no write, no ack and no error.
    - Changes on `DAD`, `SIZE` or `WRITE` during `WAIT` are ignored; the latched values are used.
  - `ACK`: `ACKD_n`=0 for exactly one cycle, then go to `IDLE` unconditionally. If `MREQ` is still 1 in the following `IDLE` cycle, it is a new request.
- Reads:
  - Data is read from the array at the edge entering `ACK`.
  - It is driven right-justified and zero-extended on `DDT` for the whole `ACK` cycle: byte = `word[8*lane +: 8]`, halfword = `word[16*lane[1] +: 16]`.
  - Sign extension is the initiator's job.
- Writes:
  - Write data arrives right-justified on `DDT`: byte in `[7:0]`, halfword in `[15:0]`.
  - `DDT` is sampled and committed at the rising edge that ends the `ACK` cycle.
  - Only the addressed byte lanes are modified.
- Error conditions. The access is still acknowledged, with no array write and read data `32'h0`. `err` is set at the end of `ACK` when any of the following holds:
  - misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0;
  - out of range: address below `BASE_ADDR` or at/above `BASE_ADDR + 4*DEPTH_WORDS`;
  - `SIZE`=2'b11.
- Array contents are not reset and are X after power-up.

## Timing
- Reset values: state `IDLE`, `ACKD_n`=1, `DDT`=`z`, `err`=0, counter 0. Reset asserted mid-transaction abandons the transaction immediately, with no write and `ACKD_n`=1 asynchronously.
- Latency, from the cycle `MREQ` is first seen high in `IDLE` to the `ACK` cycle: `WAIT_CYCLES`+1 cycles. With the default of 1 this is 2 cycles.
- Back-to-back requests: each request occupies `WAIT_CYCLES`+2 cycles including the mandatory `IDLE` cycle.
- Read-after-write to the same address, on consecutive requests, returns the new data, because the write commits before the next capture.
- `DDT` is driven only when state = `ACK` and the latched `WRITE`=0. The responder never drives `DDT` in a write `ACK` cycle.
- `ACKD_n` and the `DDT` enable are registered outputs, with no combinational path from inputs.

## Test plan
- Reset, then idle: `ACKD_n`=1, `DDT`=z, `err`=0. Assert `rst` during `WAIT` -> `ACKD_n` stays 1, and a later read shows the location unchanged.
- `WAIT_CYCLES`=2: word write of 32'hDEAD_BEEF to 0x10, then word read of 0x10 -> `ACKD_n` low on cycle 3 after capture, read returns 32'hDEAD_BEEF.
- Byte write of 8'h5A to 0x13 over word 32'h1122_3344 -> word read 32'h5A22_3344. Halfword read at 0x12 -> 32'h0000_5A22.
- Halfword read at 0x11 -> ack, `DDT`=32'h0, `err`=1. A write with `err_clr`=1 in the same cycle as a new error -> `err` stays 1. Plain `err_clr` -> `err`=0.
- `MREQ` high one cycle then low during `WAIT` (write of 32'hFFFF_FFFF to 0x20) -> no `ACKD_n` pulse, and 0x20 keeps its prior value.
- `BASE_ADDR`=32'h8000_0000 with `DEPTH_WORDS`=16: write to 32'h8000_0040 -> ack, `err`=1, no array word changed. `WAIT_CYCLES`=0 read -> ack 1 cycle after capture.
